dsd_capture_sequencer: RTL and testbench



---
 rtl/dsd_debug_pkg.sv | 8 +
 rtl/dsd_capture_buffer.sv | 22 ++
 rtl/dsd_capture_sequencer.sv | 102 ++++++++++
 tb/tb_dsd_capture_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dsd_debug_pkg.sv
// dsd_debug_pkg: shared types and helpers for the DSD capture sequencer and debug memory
package dsd_debug_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, COLLECT, WCMD, BURST, GAP, RCMD, DRAIN} cap_state_e;
  localparam int GAP_LEN = 1;
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/dsd_capture_buffer.sv
// dsd_capture_buffer: capture register file, sync write port and registered read port that returns 0 when idle
module dsd_capture_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= rd_en ? mem[rd_idx] : '0;
endmodule

// File: rtl/dsd_capture_sequencer.sv
// dsd_capture_sequencer: arms on request, captures on a signed rising level crossing or forced trigger, bursts the capture to the debug memory
module dsd_capture_sequencer
  import dsd_debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CAPTURE_LEN = 16,
  parameter int IDX_W = idx_width(CAPTURE_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] trig_level,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_W,
  output logic                  mem_R,
  output logic [DATA_WIDTH-1:0] mem_data
);
  localparam int AW = IDX_W - 1;
  localparam logic [IDX_W-1:0] LEN = IDX_W'(CAPTURE_LEN);
  localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(GAP_LEN - 1);
  cap_state_e state;
  logic [IDX_W-1:0] cnt;
  logic signed [DATA_WIDTH-1:0] level, prev;
  logic prev_valid, lvl_hit, fire, wr_en, rd_en;
  logic [AW-1:0] wr_idx, rd_idx;
  always_comb begin
    lvl_hit = prev_valid && prev < level && $signed(sample_in) >= level;
    fire = state == ARMED && (force_trig || (sample_valid && lvl_hit));
    wr_en = sample_valid && (fire || (state == COLLECT && cnt < LEN));
    wr_idx = state == ARMED ? '0 : cnt[AW-1:0];
    rd_en = state == WCMD || (state == BURST && cnt < LEN);
    rd_idx = state == WCMD ? '0 : cnt[AW-1:0];
  end
  dsd_capture_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(CAPTURE_LEN), .AW(AW)) u_buf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(sample_in),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(mem_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      level <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      mem_W <= 1'b0;
      mem_R <= 1'b0;
    end else begin
      done <= 1'b0;
      mem_W <= 1'b0;
      mem_R <= 1'b0;
      case (state)
        IDLE: if (arm) begin
          level <= trig_level;
          prev_valid <= 1'b0;
          busy <= 1'b1;
          state <= ARMED;
        end
        ARMED: if (fire) begin
          cnt <= sample_valid ? IDX_W'(1) : '0;
          state <= COLLECT;
        end else if (sample_valid) begin
          prev <= sample_in;
          prev_valid <= 1'b1;
        end
        // The full-count check lands one cycle after the last write so the buffer read is ready for beat 0.
        COLLECT: if (cnt == LEN) begin
          cnt <= '0;
          mem_W <= 1'b1;
          state <= WCMD;
        end else if (sample_valid) cnt <= cnt + 1'b1;
        WCMD: begin
          cnt <= IDX_W'(1);
          state <= BURST;
        end
        BURST: if (cnt == LEN) begin
          cnt <= '0;
          state <= GAP;
        end else cnt <= cnt + 1'b1;
        GAP: if (cnt == GAP_LAST) begin
          cnt <= '0;
          mem_R <= 1'b1;
          done <= 1'b1;
          state <= RCMD;
        end else cnt <= cnt + 1'b1;
        RCMD: begin
          cnt <= '0;
          state <= DRAIN;
        end
        DRAIN: if (cnt == LEN) begin
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dsd_capture_sequencer.sv
// tb_dsd_capture_sequencer: randomized and directed stimulus against a timeline reference model of the capture sequencer
module tb_dsd_capture_sequencer;
  localparam int DW = 32;
  localparam int LEN = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] sample_in = '0, trig_level = '0;
  logic sample_valid = 1'b0, arm = 1'b0, force_trig = 1'b0;
  logic busy, done, mem_W, mem_R;
  logic [DW-1:0] mem_data;
  int vectors = 0, miscompares = 0;
  int n = 0, m_e = 0, m_mode = 0;
  logic [DW-1:0] m_level, m_prev;
  logic m_prev_ok;
  logic [DW-1:0] q[$];

  dsd_capture_sequencer #(.DATA_WIDTH(DW), .CAPTURE_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
    .busy(busy), .done(done), .mem_W(mem_W), .mem_R(mem_R), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Mode 0 idle, 1 armed, 2 collecting, 3 output timeline relative to the edge m_e of the last captured sample.
  task automatic model_edge();
    n++;
    case (m_mode)
      0: if (arm) begin
        m_mode = 1;
        m_level = trig_level;
        m_prev_ok = 1'b0;
      end
      1: if (force_trig) begin
        m_mode = 2;
        q.delete();
        if (sample_valid) q.push_back(sample_in);
      end else if (sample_valid) begin
        if (m_prev_ok && $signed(m_prev) < $signed(m_level) && $signed(sample_in) >= $signed(m_level)) begin
          m_mode = 2;
          q.delete();
          q.push_back(sample_in);
        end else begin
          m_prev = sample_in;
          m_prev_ok = 1'b1;
        end
      end
      2: if (sample_valid) begin
        q.push_back(sample_in);
        if (q.size() == LEN) begin
          m_mode = 3;
          m_e = n;
        end
      end
      default: ;
    endcase
    if (m_mode == 3 && n - m_e >= LEN + 21) m_mode = 0;
  endtask

  task automatic check_outputs();
    int d;
    logic out;
    logic [DW-1:0] exp_data;
    d = n - m_e;
    out = m_mode == 3;
    exp_data = (out && d >= 2 && d <= LEN + 1) ? q[d-2] : '0;
    check("busy", DW'(busy), DW'(m_mode != 0));
    check("mem_W", DW'(mem_W), DW'(out && d == 1));
    check("mem_R", DW'(mem_R), DW'(out && d == LEN + 3));
    check("done", DW'(done), DW'(out && d == LEN + 3));
    check("mem_data", mem_data, exp_data);
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] d, input logic a, input logic f);
    sample_valid = v;
    sample_in = d;
    arm = a;
    force_trig = f;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_out();
    for (int i = 0; i < 200 && m_mode != 0; i++) tick(1'b0, '0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic check_reset();
    check("rst_busy", DW'(busy), '0);
    check("rst_mem_W", DW'(mem_W), '0);
    check("rst_mem_R", DW'(mem_R), '0);
    check("rst_done", DW'(done), '0);
    check("rst_mem_data", mem_data, '0);
  endtask

  task automatic arm_at(input int lvl);
    trig_level = DW'(lvl);
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1;
    check_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    // level trigger with consecutive samples
    arm_at(100);
    tick(1'b1, DW'(50), 1'b0, 1'b0);
    tick(1'b1, DW'(90), 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) tick(1'b1, DW'(120 + 10 * i + int'($urandom_range(0, 5))), 1'b0, 1'b0);
    run_out();
    // first valid sample only loads prev
    arm_at(0);
    tick(1'b1, DW'(5), 1'b0, 1'b0);
    tick(1'b1, DW'(7), 1'b0, 1'b0);
    tick(1'b1, DW'(-3), 1'b0, 1'b0);
    tick(1'b1, DW'(4), 1'b0, 1'b0);
    for (int i = 0; i < LEN + 2; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
    run_out();
    // sparse valid after trigger
    arm_at(0);
    tick(1'b1, DW'(-1), 1'b0, 1'b0);
    tick(1'b1, DW'(1), 1'b0, 1'b0);
    for (int i = 0; i < 3 * LEN; i++) tick(i % 3 == 2, DW'($urandom), 1'b0, 1'b0);
    run_out();
    // force with and without a same-cycle sample
    arm_at(1000);
    tick(1'b1, DW'(32'hDEAD), 1'b0, 1'b1);
    for (int i = 0; i < LEN; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
    run_out();
    arm_at(1000);
    idle(2);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < LEN; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
    // arm pulsed during the burst is ignored
    idle(5);
    tick(1'b0, '0, 1'b1, 1'b0);
    run_out();
    // force in idle is ignored; signed negative threshold
    tick(1'b1, DW'(77), 1'b0, 1'b1);
    idle(2);
    arm_at(-10);
    tick(1'b1, DW'(-20), 1'b0, 1'b0);
    tick(1'b1, DW'(-5), 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
    // async reset while beat 7 is on the bus
    for (int i = 0; i < 50 && !(m_mode == 3 && n - m_e == 9); i++) tick(1'b0, '0, 1'b0, 1'b0);
    check("beat7_reached", DW'(m_mode == 3 && n - m_e == 9), DW'(1));
    #2 rst = 1'b1;
    #1;
    check_reset();
    m_mode = 0;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    arm_at(50);
    tick(1'b1, DW'(10), 1'b0, 1'b0);
    tick(1'b1, DW'(60), 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
    run_out();
    // randomized traffic around a small threshold range
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) trig_level = DW'(int'($urandom_range(0, 200)) - 100);
      tick($urandom_range(0, 1) == 1, DW'(int'($urandom_range(0, 400)) - 200),
           $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
    end
    run_out();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
